// File: rtl/ppwm_pkg.sv
// ppwm_pkg: shared types and constants for the PWM program store
package ppwm_pkg;
  typedef enum logic [1:0] {StIdle, StLoad, StDone} progmem_state_e;
  localparam logic [31:0] INSTR_NOP = '0;
endpackage

// File: rtl/ppwm_prog_mem_if.sv
// ppwm_prog_mem_if: serial load pins plus the executor's pc/instruction fetch port
interface ppwm_prog_mem_if #(parameter int INSTR_WIDTH = 6, parameter int PC_WIDTH = 4);
  logic load_en;
  logic data_valid;
  logic data;
  logic [PC_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic loading;
  logic load_done;
  modport master (output load_en, data_valid, data, pc, input instr, loading, load_done);
  modport slave (input load_en, data_valid, data, pc, output instr, loading, load_done);
endinterface

// File: rtl/ppwm_deser.sv
// ppwm_deser: MSB-first serial-to-parallel word assembler with bit counter
module ppwm_deser #(parameter int INSTR_WIDTH = 6) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic                   data_i,
  output logic [INSTR_WIDTH-1:0] word_o,
  output logic                   word_valid_o
);
  localparam int CW = $clog2(INSTR_WIDTH);
  logic [INSTR_WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign word_o = {shift_q, data_i};
  assign word_valid_o = valid_i & ~clear_i & (cnt_q == CW'(INSTR_WIDTH - 1));
  always_comb begin
    shift_d = clear_i ? '0 : valid_i ? word_o[INSTR_WIDTH-2:0] : shift_q;
    cnt_d = (clear_i | word_valid_o) ? '0 : valid_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ppwm_prog_mem.sv
// ppwm_prog_mem: serially loaded program store with zero-latency reads for the executor
module ppwm_prog_mem
  import ppwm_pkg::*;
#(
  parameter int INSTR_WIDTH = 6,
  parameter int PC_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  ppwm_prog_mem_if.slave bus
);
  localparam int DEPTH = 2 ** PC_WIDTH;
  progmem_state_e state_q, state_d;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_d [DEPTH];
  logic [PC_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic load_en_q, rise, fall, loading, word_valid;
  logic [INSTR_WIDTH-1:0] word;
  assign loading = state_q == StLoad;
  assign rise = bus.load_en & ~load_en_q;
  assign fall = ~bus.load_en & load_en_q;
  // an abort drops any bit strobed in the same cycle
  ppwm_deser #(.INSTR_WIDTH(INSTR_WIDTH)) u_deser (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (rise | fall),
    .valid_i     (loading & bus.data_valid & ~fall),
    .data_i      (bus.data),
    .word_o      (word),
    .word_valid_o(word_valid)
  );
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    mem_d = mem_q;
    case (state_q)
      StIdle, StDone: if (rise) begin
        state_d = StLoad;
        wr_ptr_d = '0;
      end
      StLoad: if (fall) state_d = StIdle;
        else if (word_valid) begin
          mem_d[wr_ptr_q] = word;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d = &wr_ptr_q ? StDone : StLoad;
        end
      default: state_d = StIdle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wr_ptr_q <= '0;
      load_en_q <= 1'b0;
      mem_q <= '{default: INSTR_WIDTH'(INSTR_NOP)};
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      load_en_q <= bus.load_en;
      mem_q <= mem_d;
    end
  end
  assign bus.instr = loading ? '0 : mem_q[bus.pc];
  assign bus.loading = loading;
  assign bus.load_done = state_q == StDone;
endmodule
